dbi_tx_fsm: RTL
===============

# dbi_tx_fsm

- Drives the LCD panel over an 8-bit MIPI DBI Type-B (8080-style) write-only bus.
- Consumes the RGB565 byte stream from the gray-to-RGB converter through a valid/ready handshake.
- On each frame request it sends the address-window commands, then RAMWR (0x2C), then exactly `2*IMG_W*IMG_H` pixel bytes, with panel write strobes timed by parameters.
- Last stage before the panel pins; reports busy and frame completion to the top-level controller.

## Interface
- `DATA_W`, 8, bus and pixel byte width
- `IMG_W`, 320, frame width in pixels (1..65536)
- `IMG_H`, 240, frame height in pixels (1..65536)
- `WR_LOW_CYC`, 1, `clk` cycles WRX is held low per byte (≥1)
- `WR_HIGH_CYC`, 1, `clk` cycles WRX is held high per byte (≥1)

- `clk`  in  1  single clock; all logic on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `frame_start_i`  in  1  frame request; sampled only in IDLE
- `pxl_dat_i`  in  DATA_W  pixel byte from the converter
- `pxl_vld_i`  in  1  pixel byte valid
- `pxl_rdy_o`  out  1  pixel byte accepted when `pxl_vld_i & pxl_rdy_o`
- `busy_o`  out  1  frame in progress
- `frame_done_o`  out  1  one-cycle pulse when a frame completes
- `dbi_csx_o`  out  1  chip select, active low
- `dbi_dcx_o`  out  1  0 = command byte, 1 = parameter or pixel byte
- `dbi_wrx_o`  out  1  write strobe; panel latches on its rising edge
- `dbi_rdx_o`  out  1  read strobe; constant 1 (block is write-only)
- `dbi_d_o`  out  DATA_W  bus data

## Operation
- **States:** IDLE, WR_LO, WR_HI, PIX_WAIT, END.
- **Byte sequencer index selects the next byte:**
  - CASET 0x2A (DCX=0), then params 0x00, 0x00, (IMG_W-1)[15:8], (IMG_W-1)[7:0].
  - PASET 0x2B (DCX=0), then params 0x00, 0x00, (IMG_H-1)[15:8], (IMG_H-1)[7:0].
  - RAMWR 0x2C (DCX=0).
  - Pixel bytes (DCX=1).
- **IDLE:**
  - `frame_start_i`=1 → WR_LO carrying the first sequence byte; `busy_o`←1.
  - `frame_start_i` is ignored in every other state.
- **WR_LO:**
  - WRX=0, CSX=0; D and DCX stay stable for the whole byte period.
  - After WR_LOW_CYC cycles → WR_HI.
- **WR_HI:**
  - WRX=1; D and DCX held.
  - On the last WR_HI cycle, non-pixel next byte → WR_LO with that byte.
  - Pixel byte still owed, with a handshake on the last cycle → WR_LO with the captured `pxl_dat_i`.
  - Pixel byte still owed, no handshake → PIX_WAIT.
  - No bytes remain → END.
- **PIX_WAIT:**
  - WRX=1, CSX=0; D and DCX hold the previous byte.
  - On handshake → WR_LO.
- **END:** one cycle with CSX=1 and `frame_done_o`=1, then IDLE with `busy_o`←0.
- **`pxl_rdy_o`**, registered-state decode:
  - 1 in PIX_WAIT.
  - 1 on the last WR_HI cycle whenever the next byte is a pixel byte; this includes the cycle after RAMWR.
  - 0 otherwise.
- **Pixel byte counter:**
  - Width is `$clog2(2*IMG_W*IMG_H+1)`.
  - Cleared on frame start; increments on each handshake.
  - Once it reaches `2*IMG_W*IMG_H`, no further handshakes occur.
- **Byte order:** bytes are forwarded in arrival order; the block does not reorder bytes.
- **Reset values:** CSX=1, DCX=1, WRX=1, RDX=1, D=0, `pxl_rdy_o`=0, `busy_o`=0, `frame_done_o`=0; state IDLE; counters 0.
- **Reset mid-frame:** outputs take reset values immediately (asynchronously) and the partial frame is abandoned. Upstream must be flushed by the top level.

## Timing
- Latency from `frame_start_i` high in IDLE (edge T0): at T0+1, CSX=0, WRX=0, DCX=0, D = first command.
- Byte period is exactly WR_LOW_CYC+WR_HIGH_CYC cycles when the source never stalls.
- Stall extends the WRX-high time only; WRX never goes low without a byte.
- CSX stays low from the first WR_LO until END, including stalls.
- Handshake at edge T → WR_LO with that byte from T+1.
- `frame_done_o` is high exactly in the END cycle; `busy_o` falls at the edge leaving END.
- Frame length with no stalls and the macro defined: (11 + 2·IMG_W·IMG_H)·(WR_LOW_CYC+WR_HIGH_CYC) + 1 END cycle.

## Configuration
- `DBI_TX_ADDR_WIN_EN`:
  - Defined: each frame sends CASET/PASET with their 8 parameters before RAMWR.
  - Undefined: the sequence starts directly at RAMWR 0x2C, and the first WR_LO at T0+1 carries 0x2C.
  - Sequencer and frame length shrink accordingly (1 command byte instead of 11).

## Test plan
- **Reset:** assert `rst_n`=0 mid-WR_LO → same cycle CSX=1, WRX=1, D=0, `busy_o`=0; after release, no strobes until `frame_start_i`.
- **Full frame, no stalls:** IMG_W=4, IMG_H=2, WR_LOW/HIGH=1, macro defined, `pxl_vld_i` always 1 with bytes 0x00..0x0F.
  - Bus captures 2A 00 00 00 03 2B 00 00 00 01 2C (DCX=0 on 2A, 2B, 2C), then 00..0F with DCX=1.
  - `frame_done_o` pulses at cycle 55; 16 handshakes total.
- **Stall:** same setup, `pxl_vld_i`=0 for 5 cycles after byte 0x07 → WRX high, CSX low throughout the stall; next strobe carries 0x08 and no byte is duplicated.
- **Timing parameters:** WR_LOW_CYC=3, WR_HIGH_CYC=2 → every WRX low pulse lasts 3 cycles, each high gap lasts ≥2 cycles, and D is constant across each 5-cycle period.
- **Ignored request:** pulse `frame_start_i` mid-frame → no change; exactly 16 pixel bytes and one `frame_done_o`.
- **Macro undefined:** first strobed byte is 0x2C with DCX=0 at T0+1; `frame_done_o` at cycle 35 for the 4×2 frame.

Source files
------------

// File: rtl/dbi_tx_fsm.sv
// MIPI DBI Type-B (8080) write-only transmitter: address window, RAMWR, then the pixel stream.
// Define DBI_TX_ADDR_WIN_EN to send CASET/PASET before RAMWR on every frame.
module dbi_tx_fsm #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned IMG_W       = 320,
    parameter int unsigned IMG_H       = 240,
    parameter int unsigned WR_LOW_CYC  = 1,
    parameter int unsigned WR_HIGH_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start_i,
    input  logic [DATA_W-1:0] pxl_dat_i,
    input  logic              pxl_vld_i,
    output logic              pxl_rdy_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              dbi_csx_o,
    output logic              dbi_dcx_o,
    output logic              dbi_wrx_o,
    output logic              dbi_rdx_o,
    output logic [DATA_W-1:0] dbi_d_o
);

    localparam longint unsigned PIX_BYTES = 2 * longint'(IMG_W) * longint'(IMG_H);
    localparam int unsigned PCNT_W  = $clog2(PIX_BYTES + 1);
    localparam int unsigned CYC_MAX = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
`ifdef DBI_TX_ADDR_WIN_EN
    localparam int unsigned NUM_CMD = 11;
    localparam logic [15:0] W_LAST  = 16'(IMG_W - 1);
    localparam logic [15:0] H_LAST  = 16'(IMG_H - 1);
`else
    localparam int unsigned NUM_CMD = 1;
`endif
    localparam int unsigned IDX_W = $clog2(NUM_CMD + 1);

    typedef enum logic [2:0] {StIdle, StWrLo, StWrHi, StPixWait, StEnd} state_t;

    state_t             state;
    logic [CYC_W-1:0]   cyc;
    logic [IDX_W-1:0]   seq_idx;   // index of the next command/parameter byte
    logic [PCNT_W-1:0]  pix_cnt;
    logic [DATA_W-1:0]  next_cmd;
    logic               cmd_owed;
    logic               pix_owed;
    logic               last_cyc;

`ifdef DBI_TX_ADDR_WIN_EN
    always_comb begin
        next_cmd = '0;
        case (seq_idx)
            4'd0:    next_cmd = DATA_W'(8'h2A);
            4'd3:    next_cmd = DATA_W'(W_LAST[15:8]);
            4'd4:    next_cmd = DATA_W'(W_LAST[7:0]);
            4'd5:    next_cmd = DATA_W'(8'h2B);
            4'd8:    next_cmd = DATA_W'(H_LAST[15:8]);
            4'd9:    next_cmd = DATA_W'(H_LAST[7:0]);
            4'd10:   next_cmd = DATA_W'(8'h2C);
            default: next_cmd = '0;
        endcase
    end
`else
    assign next_cmd = DATA_W'(8'h2C);
`endif

    assign cmd_owed  = (seq_idx < IDX_W'(NUM_CMD));
    assign pix_owed  = (pix_cnt < PCNT_W'(PIX_BYTES));
    assign last_cyc  = (cyc == '0);
    assign dbi_rdx_o = 1'b1;

    // Ready is offered only when the byte slot after the current strobe is a pixel slot.
    assign pxl_rdy_o = (state == StPixWait) ||
                       ((state == StWrHi) && last_cyc && !cmd_owed && pix_owed);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            cyc          <= '0;
            seq_idx      <= '0;
            pix_cnt      <= '0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            dbi_csx_o    <= 1'b1;
            dbi_dcx_o    <= 1'b1;
            dbi_wrx_o    <= 1'b1;
            dbi_d_o      <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (frame_start_i) begin
                        state     <= StWrLo;
                        busy_o    <= 1'b1;
                        dbi_csx_o <= 1'b0;
                        dbi_wrx_o <= 1'b0;
                        dbi_dcx_o <= 1'b0;
                        dbi_d_o   <= next_cmd;
                        seq_idx   <= IDX_W'(1);
                        pix_cnt   <= '0;
                        cyc       <= CYC_W'(WR_LOW_CYC - 1);
                    end
                end
                StWrLo: begin
                    if (last_cyc) begin
                        state     <= StWrHi;
                        dbi_wrx_o <= 1'b1;
                        cyc       <= CYC_W'(WR_HIGH_CYC - 1);
                    end else begin
                        cyc <= cyc - CYC_W'(1);
                    end
                end
                StWrHi: begin
                    if (!last_cyc) begin
                        cyc <= cyc - CYC_W'(1);
                    end else if (cmd_owed) begin
                        state     <= StWrLo;
                        dbi_wrx_o <= 1'b0;
                        dbi_dcx_o <= 1'b0;
                        dbi_d_o   <= next_cmd;
                        seq_idx   <= seq_idx + IDX_W'(1);
                        cyc       <= CYC_W'(WR_LOW_CYC - 1);
                    end else if (pix_owed) begin
                        if (pxl_vld_i) begin
                            state     <= StWrLo;
                            dbi_wrx_o <= 1'b0;
                            dbi_dcx_o <= 1'b1;
                            dbi_d_o   <= pxl_dat_i;
                            pix_cnt   <= pix_cnt + PCNT_W'(1);
                            cyc       <= CYC_W'(WR_LOW_CYC - 1);
                        end else begin
                            state <= StPixWait;
                        end
                    end else begin
                        state        <= StEnd;
                        dbi_csx_o    <= 1'b1;
                        frame_done_o <= 1'b1;
                    end
                end
                StPixWait: begin
                    if (pxl_vld_i) begin
                        state     <= StWrLo;
                        dbi_wrx_o <= 1'b0;
                        dbi_dcx_o <= 1'b1;
                        dbi_d_o   <= pxl_dat_i;
                        pix_cnt   <= pix_cnt + PCNT_W'(1);
                        cyc       <= CYC_W'(WR_LOW_CYC - 1);
                    end
                end
                StEnd: begin
                    state        <= StIdle;
                    busy_o       <= 1'b0;
                    frame_done_o <= 1'b0;
                    seq_idx      <= '0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
